fpga_robots_game_reset: RTL and testbench

FPGA_ROBOTS_GAME_RESET -- requirements
Module: fpga_robots_game_reset

---
 rtl/fpga_robots_game_reset.sv | 149 ++++++++++++++
 tb/tb_fpga_robots_game_reset.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fpga_robots_game_reset.sv
// -----------------------------------------------------------------------------
// fpga_robots_game_reset
//
// Reset sequencer for the robots game. It waits for both PLLs to report lock,
// requires that lock to hold for STABLE_CYCLES clocks, then holds the game
// reset for RESET_HOLD more clocks before releasing it. A lock loss while
// running re-asserts reset at once and restarts the whole sequence. The game
// logic can also ask for a fresh reset hold with soft_rst.
//
// Ports
//   clk         game clock, rising edge
//   rst         asynchronous active-high reset
//   locked_a    PLL LOCKED inputs, asynchronous to clk, one bit per PLL
//   soft_rst    single-cycle request to re-run the reset hold (RUN only)
//   clear_lost  clears the sticky lost flag
//   rst_out     registered active-high reset for the game logic
//   ready       inverse of rst_out
//   lost        sticky flag, set when lock drops while running
//   loss_count  saturating count of lock losses
//
// Build option
//   FPGA_ROBOTS_GAME_RESET_LOSSCNT_EN  when defined, loss_count counts every
//   RUN -> WAIT transition and saturates at 255; otherwise it is tied to 0.
//
// States
//   WAIT   | synchronized lock low, counters cleared
//   STABLE | lock high, counting STABLE_CYCLES consecutive cycles
//   DRAIN  | lock stable, holding reset for RESET_HOLD cycles
//   RUN    | reset released, game running
// -----------------------------------------------------------------------------
module fpga_robots_game_reset #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 65536,
    parameter int RESET_HOLD    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] locked_a,
    input  logic       soft_rst,
    input  logic       clear_lost,
    output logic       rst_out,
    output logic       ready,
    output logic       lost,
    output logic [7:0] loss_count
);

    localparam int SC_W = $clog2(STABLE_CYCLES + 1);
    localparam int HC_W = $clog2(RESET_HOLD + 1);

    localparam logic [SC_W-1:0] SC_LAST = SC_W'(STABLE_CYCLES - 1);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(RESET_HOLD - 1);

    localparam logic [1:0] S_WAIT   = 2'd0;
    localparam logic [1:0] S_STABLE = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_RUN    = 2'd3;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lk;
    logic [1:0]             state, state_nxt;
    logic [SC_W-1:0]        sc, sc_nxt;
    logic [HC_W-1:0]        hc, hc_nxt;
    logic                   lost_set;

    // Both PLLs are combined before synchronizing so a single lock bit
    // crosses into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], &locked_a};
        end
    end

    assign lk = sync_q[SYNC_STAGES-1];

    // Counters default to zero so every state change starts them clean;
    // they only advance while the FSM stays in its counting state and stop
    // at the terminal value, so they can never wrap.
    always_comb begin
        state_nxt = state;
        sc_nxt    = '0;
        hc_nxt    = '0;
        lost_set  = 1'b0;
        case (state)
            S_WAIT: begin
                if (lk) state_nxt = S_STABLE;
            end
            S_STABLE: begin
                if (!lk)                state_nxt = S_WAIT;
                else if (sc == SC_LAST) state_nxt = S_DRAIN;
                else                    sc_nxt    = sc + 1'b1;
            end
            S_DRAIN: begin
                if (!lk)                state_nxt = S_WAIT;
                else if (hc == HC_LAST) state_nxt = S_RUN;
                else                    hc_nxt    = hc + 1'b1;
            end
            S_RUN: begin
                // Lock loss takes priority over a coincident soft reset.
                if (!lk) begin
                    state_nxt = S_WAIT;
                    lost_set  = 1'b1;
                end else if (soft_rst) begin
                    state_nxt = S_DRAIN;
                end
            end
            default: state_nxt = S_WAIT;
        endcase
    end

    // rst_out is decoded from state_nxt and registered alongside state, so it
    // is a clean flop output that is low exactly while state is RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_WAIT;
            sc      <= '0;
            hc      <= '0;
            rst_out <= 1'b1;
            lost    <= 1'b0;
        end else begin
            state   <= state_nxt;
            sc      <= sc_nxt;
            hc      <= hc_nxt;
            rst_out <= (state_nxt != S_RUN);
            if (lost_set)        lost <= 1'b1;
            else if (clear_lost) lost <= 1'b0;
        end
    end

    assign ready = ~rst_out;

`ifdef FPGA_ROBOTS_GAME_RESET_LOSSCNT_EN
    logic [7:0] loss_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loss_cnt_q <= 8'd0;
        end else if (lost_set && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_q <= loss_cnt_q + 8'd1;
        end
    end

    assign loss_count = loss_cnt_q;
`else
    assign loss_count = 8'd0;
`endif

endmodule

// File: tb/tb_fpga_robots_game_reset.sv
module tb_fpga_robots_game_reset;

    logic       clk;
    logic       rst;
    logic [1:0] locked_a;
    logic       soft_rst;
    logic       clear_lost;
    logic       rst_out;
    logic       ready;
    logic       lost;
    logic [7:0] loss_count;

    typedef struct {
        string       tag;
        logic [10:0] val;   // {rst_out, ready, lost, loss_count}
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   losses     = 0;

    fpga_robots_game_reset #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (4),
        .RESET_HOLD    (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .locked_a   (locked_a),
        .soft_rst   (soft_rst),
        .clear_lost (clear_lost),
        .rst_out    (rst_out),
        .ready      (ready),
        .lost       (lost),
        .loss_count (loss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] lc_exp();
`ifdef FPGA_ROBOTS_GAME_RESET_LOSSCNT_EN
        return (losses > 255) ? 8'd255 : 8'(losses);
`else
        return 8'd0;
`endif
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string tag, input logic ro, input logic lo);
        exp_t e;
        e.tag = tag;
        e.val = {ro, ~ro, lo, lc_exp()};
        sb.push_back(e);
    endtask

    task automatic compare_out();
        exp_t        e;
        logic [10:0] obs;
        obs = {rst_out, ready, lost, loss_count};
        compared++;
        if (sb.size() == 0) begin
            mismatched++;
            $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                mismatched++;
                $error("FAIL %s observed={rst_out,ready,lost,loss_count}=%h expected=%h",
                       e.tag, obs, e.val);
            end
        end
    endtask

    // Push the expectation for the state after n more edges, advance, compare.
    task automatic step(input int n, input string tag, input logic ro, input logic lo);
        push_exp(tag, ro, lo);
        tick(n);
        compare_out();
    endtask

    initial begin
        rst        = 1'b1;
        locked_a   = 2'b00;
        soft_rst   = 1'b0;
        clear_lost = 1'b0;

        #3;
        step(0, "reset_init", 1'b1, 1'b0);
        tick(2);

        // Power-up: rst_out falls on the 10th edge after lock is applied.
        rst      = 1'b0;
        locked_a = 2'b11;
        step(9, "pwr_e9", 1'b1, 1'b0);
        step(1, "pwr_e10", 1'b0, 1'b0);

        // soft_rst in RUN: reset held for exactly 3 cycles.
        soft_rst = 1'b1;
        step(1, "soft_e1", 1'b1, 1'b0);
        soft_rst = 1'b0;
        step(2, "soft_e3", 1'b1, 1'b0);
        step(1, "soft_e4", 1'b0, 1'b0);

        // soft_rst held into DRAIN must not restart the hold.
        soft_rst = 1'b1;
        step(1, "drain_enter", 1'b1, 1'b0);
        step(1, "drain_soft_e2", 1'b1, 1'b0);
        soft_rst = 1'b0;
        step(1, "drain_e3", 1'b1, 1'b0);
        step(1, "drain_e4", 1'b0, 1'b0);

        // Lock loss in RUN; clear_lost on the setting edge loses to the set.
        locked_a = 2'b10;
        step(2, "loss_e2", 1'b0, 1'b0);
        clear_lost = 1'b1;
        losses     = 1;
        step(1, "loss_e3", 1'b1, 1'b1);
        clear_lost = 1'b0;
        locked_a   = 2'b11;
        step(9, "relock_e9", 1'b1, 1'b1);
        step(1, "relock_e10", 1'b0, 1'b1);
        clear_lost = 1'b1;
        step(1, "clear_lost", 1'b0, 1'b0);
        clear_lost = 1'b0;

        // Glitch during STABLE restarts the stability count.
        locked_a = 2'b00;
        losses   = 2;
        step(3, "drop_e3", 1'b1, 1'b1);
        locked_a = 2'b11;
        step(3, "glitch_pre", 1'b1, 1'b1);
        locked_a = 2'b01;
        step(3, "glitch_mid", 1'b1, 1'b1);
        locked_a = 2'b11;
        step(9, "glitch_e9", 1'b1, 1'b1);
        step(1, "glitch_e10", 1'b0, 1'b1);

        // Simultaneous soft_rst and lock loss: the loss wins.
        clear_lost = 1'b1;
        step(1, "clear_again", 1'b0, 1'b0);
        clear_lost = 1'b0;
        locked_a   = 2'b00;
        step(2, "sim_e2", 1'b0, 1'b0);
        soft_rst = 1'b1;
        losses   = 3;
        step(1, "sim_e3", 1'b1, 1'b1);
        soft_rst   = 1'b0;
        clear_lost = 1'b1;
        step(1, "sim_clear", 1'b1, 1'b0);
        clear_lost = 1'b0;

        // Async reset between edges while in DRAIN.
        locked_a = 2'b11;
        step(8, "pre_drain", 1'b1, 1'b0);
        #2;
        rst    = 1'b1;
        losses = 0;
        step(0, "async_drain", 1'b1, 1'b0);
        rst = 1'b0;
        step(9, "rerun_e9", 1'b1, 1'b0);
        step(1, "rerun_e10", 1'b0, 1'b0);

        // Async reset while running forces rst_out high before any edge.
        #2;
        rst = 1'b1;
        step(0, "async_run", 1'b1, 1'b0);
        rst = 1'b0;
        step(9, "rerun2_e9", 1'b1, 1'b0);
        step(1, "rerun2_e10", 1'b0, 1'b0);

        // 300 forced losses exercise loss_count saturation.
        for (int i = 0; i < 300; i++) begin
            locked_a = 2'b00;
            tick(3);
            losses++;
            locked_a = 2'b11;
            tick(10);
        end
        step(0, "loss_sat", 1'b0, 1'b1);

        $display("lock losses driven: %0d", losses);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
